// File: rtl/memory_stage_lsu_if.sv
// Execute, dcache, writeback and hazard signals around the memory stage.
// master = the memory stage itself, slave = the surrounding pipeline/cache.
interface memory_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              execute_memory_valid;
  logic              execute_memory_load;
  logic              execute_memory_store;
  logic [2:0]        execute_memory_funct3;
  logic [XLEN-1:0]   execute_memory_addr;
  logic [XLEN-1:0]   execute_memory_wdata;
  logic [XLEN-1:0]   execute_memory_result;
  logic [4:0]        execute_memory_rd;
  logic              memory_execute_ready;

  logic [XLEN-1:0]   memory_dcache_addr;
  logic              memory_dcache_read;
  logic              memory_dcache_write;
  logic [XLEN-1:0]   memory_dcache_wdata;
  logic [XLEN/8-1:0] memory_dcache_wmask;
  logic [XLEN-1:0]   dcache_memory_rdata;
  logic              dcache_memory_resp;

  logic              memory_writeback_valid;
  logic [4:0]        memory_writeback_rd;
  logic [XLEN-1:0]   memory_writeback_data;

  logic              memory_hazard_stall;
  logic              memory_hazard_pc_redirect;
  logic [1:0]        memory_hazard_cause;

  modport master (
    input  execute_memory_valid, execute_memory_load, execute_memory_store,
           execute_memory_funct3, execute_memory_addr, execute_memory_wdata,
           execute_memory_result, execute_memory_rd,
           dcache_memory_rdata, dcache_memory_resp,
    output memory_execute_ready,
           memory_dcache_addr, memory_dcache_read, memory_dcache_write,
           memory_dcache_wdata, memory_dcache_wmask,
           memory_writeback_valid, memory_writeback_rd, memory_writeback_data,
           memory_hazard_stall, memory_hazard_pc_redirect, memory_hazard_cause
  );

  modport slave (
    output execute_memory_valid, execute_memory_load, execute_memory_store,
           execute_memory_funct3, execute_memory_addr, execute_memory_wdata,
           execute_memory_result, execute_memory_rd,
           dcache_memory_rdata, dcache_memory_resp,
    input  memory_execute_ready,
           memory_dcache_addr, memory_dcache_read, memory_dcache_write,
           memory_dcache_wdata, memory_dcache_wmask,
           memory_writeback_valid, memory_writeback_rd, memory_writeback_data,
           memory_hazard_stall, memory_hazard_pc_redirect, memory_hazard_cause
  );
endinterface

// File: rtl/memory_stage_lsu.sv
// Pipeline memory stage: ALU pass-through, dcache load/store with held handshake,
// byte-lane steering, load extension, misalign trap and dcache timeout.
module memory_stage_lsu #(
  parameter int XLEN          = 32,
  parameter int TIMEOUT       = 255,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  memory_stage_lsu_if.master bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic              load_reg;
  logic [2:0]        f3_reg;
  logic [OFFW-1:0]   off_reg;
  logic [4:0]        rd_reg;
  logic [XLEN-1:0]   dc_addr_reg;
  logic              dc_read_reg;
  logic              dc_write_reg;
  logic [XLEN-1:0]   dc_wdata_reg;
  logic [NB-1:0]     dc_wmask_reg;
  logic              wb_valid_reg;
  logic [4:0]        wb_rd_reg;
  logic [XLEN-1:0]   wb_data_reg;
  logic              stall_reg;
  logic              redirect_reg;
  logic [1:0]        cause_reg;

  // Request decode: illegal widths for this XLEN collapse to a plain word access.
  logic [2:0]        f3_norm;
  logic [OFFW-1:0]   size_low;
  logic [NB-1:0]     size_mask;
  logic [OFFW-1:0]   eff_off;
  logic              misaligned;
  logic              is_mem;

  always_comb begin
    f3_norm = bus.execute_memory_funct3;
    if (f3_norm == 3'd7 || (XLEN == 32 && (f3_norm == 3'd3 || f3_norm == 3'd6)))
      f3_norm = 3'd2;
    size_low   = OFFW'((32'd1 << f3_norm[1:0]) - 32'd1);
    size_mask  = NB'((32'd1 << (32'd1 << f3_norm[1:0])) - 32'd1);
    misaligned = |(bus.execute_memory_addr[OFFW-1:0] & size_low);
    eff_off    = bus.execute_memory_addr[OFFW-1:0] & ~size_low;
    is_mem     = bus.execute_memory_load | bus.execute_memory_store;
  end

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  always_comb begin
    shifted = bus.dcache_memory_rdata >> {off_reg, 3'b000};
    case (f3_reg)
      3'd0:    load_data = XLEN'($signed(shifted[7:0]));
      3'd1:    load_data = XLEN'($signed(shifted[15:0]));
      3'd2:    load_data = XLEN'($signed(shifted[31:0]));
      3'd4:    load_data = XLEN'(shifted[7:0]);
      3'd5:    load_data = XLEN'(shifted[15:0]);
      3'd6:    load_data = XLEN'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      load_reg     <= 1'b0;
      f3_reg       <= '0;
      off_reg      <= '0;
      rd_reg       <= '0;
      dc_addr_reg  <= '0;
      dc_read_reg  <= 1'b0;
      dc_write_reg <= 1'b0;
      dc_wdata_reg <= '0;
      dc_wmask_reg <= '0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      stall_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      cause_reg    <= '0;
    end else begin
      wb_valid_reg <= 1'b0;
      redirect_reg <= 1'b0;
      cause_reg    <= '0;
      case (state_reg)
        IDLE: begin
          if (bus.execute_memory_valid && !is_mem) begin
            wb_valid_reg <= 1'b1;
            wb_data_reg  <= bus.execute_memory_result;
            wb_rd_reg    <= bus.execute_memory_rd;
          end else if (bus.execute_memory_valid) begin
            load_reg <= bus.execute_memory_load;
            f3_reg   <= f3_norm;
            off_reg  <= eff_off;
            rd_reg   <= bus.execute_memory_rd;
            if (MISALIGN_TRAP && misaligned) begin
              redirect_reg <= 1'b1;
              cause_reg    <= bus.execute_memory_load ? 2'd1 : 2'd2;
            end else begin
              state_reg    <= ACCESS;
              cnt_reg      <= '0;
              stall_reg    <= 1'b1;
              dc_addr_reg  <= {bus.execute_memory_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              dc_read_reg  <= bus.execute_memory_load;
              dc_write_reg <= !bus.execute_memory_load;
              dc_wdata_reg <= bus.execute_memory_wdata << {eff_off, 3'b000};
              dc_wmask_reg <= bus.execute_memory_load ? '0 : (size_mask << eff_off);
            end
          end
        end
        ACCESS: begin
          // A response on the timeout cycle still completes the access normally.
          if (bus.dcache_memory_resp) begin
            state_reg    <= IDLE;
            stall_reg    <= 1'b0;
            dc_read_reg  <= 1'b0;
            dc_write_reg <= 1'b0;
            dc_wmask_reg <= '0;
            if (load_reg) begin
              wb_valid_reg <= 1'b1;
              wb_data_reg  <= load_data;
              wb_rd_reg    <= rd_reg;
            end
          end else if (TIMEOUT != 0 && cnt_reg == CNTW'(TIMEOUT - 1)) begin
            state_reg    <= IDLE;
            stall_reg    <= 1'b0;
            dc_read_reg  <= 1'b0;
            dc_write_reg <= 1'b0;
            dc_wmask_reg <= '0;
            redirect_reg <= 1'b1;
            cause_reg    <= 2'd3;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign bus.memory_execute_ready      = !rst && (state_reg == IDLE);
  assign bus.memory_dcache_addr        = dc_addr_reg;
  assign bus.memory_dcache_read        = dc_read_reg;
  assign bus.memory_dcache_write       = dc_write_reg;
  assign bus.memory_dcache_wdata       = dc_wdata_reg;
  assign bus.memory_dcache_wmask       = dc_wmask_reg;
  assign bus.memory_writeback_valid    = wb_valid_reg;
  assign bus.memory_writeback_rd       = wb_rd_reg;
  assign bus.memory_writeback_data     = wb_data_reg;
  assign bus.memory_hazard_stall       = stall_reg;
  assign bus.memory_hazard_pc_redirect = redirect_reg;
  assign bus.memory_hazard_cause       = cause_reg;
endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu (XLEN=32, TIMEOUT=4, trap on misalign):
// per-cycle expectations from an arithmetic model, checked on every falling edge.
module tb_memory_stage_lsu;
  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_lsu_if #(.XLEN(XLEN)) bus ();

  memory_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TMO), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  logic        exp_ready, exp_read, exp_write, exp_wb_valid, exp_stall, exp_redirect;
  logic [1:0]  exp_cause;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [3:0]  exp_wmask;
  logic [4:0]  exp_wb_rd;
  logic [31:0] last_wb_data = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Architectural model: plain arithmetic on byte counts and offsets.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_unsigned(input logic [2:0] f3);
    return f3 == 3'd4 || f3 == 3'd5;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int n, off;
    longint unsigned v, span;
    n    = nbytes(f3);
    off  = int'(addr % 4);
    span = 64'd1 << (8 * n);
    v    = (64'(rdata) / (64'd1 << (8 * off))) % span;
    if (!is_unsigned(f3) && n < 4 && v >= span / 2)
      v = v + 64'h1_0000_0000 - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [31:0] addr);
    return 32'(64'(wd) * (64'd1 << (8 * int'(addr % 4))));
  endfunction

  function automatic logic [3:0] model_wmask(input logic [31:0] addr, input logic [2:0] f3);
    return 4'(((1 << nbytes(f3)) - 1) * (1 << int'(addr % 4)));
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("ready", 64'(bus.memory_execute_ready), 64'(exp_ready));
      chk("dc_read", 64'(bus.memory_dcache_read), 64'(exp_read));
      chk("dc_write", 64'(bus.memory_dcache_write), 64'(exp_write));
      chk("stall", 64'(bus.memory_hazard_stall), 64'(exp_stall));
      chk("wb_valid", 64'(bus.memory_writeback_valid), 64'(exp_wb_valid));
      chk("redirect", 64'(bus.memory_hazard_pc_redirect), 64'(exp_redirect));
      chk("cause", 64'(bus.memory_hazard_cause), 64'(exp_cause));
      if (exp_read || exp_write) chk("dc_addr", 64'(bus.memory_dcache_addr), 64'(exp_addr));
      if (exp_write) begin
        chk("dc_wdata", 64'(bus.memory_dcache_wdata), 64'(exp_wdata));
        chk("dc_wmask", 64'(bus.memory_dcache_wmask), 64'(exp_wmask));
      end
      if (exp_wb_valid) begin
        chk("wb_data", 64'(bus.memory_writeback_data), 64'(exp_wb_data));
        chk("wb_rd", 64'(bus.memory_writeback_rd), 64'(exp_wb_rd));
      end
      if (bus.memory_writeback_valid) last_wb_data = bus.memory_writeback_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_ready = 1'b1; exp_read = 1'b0; exp_write = 1'b0; exp_stall = 1'b0;
    exp_wb_valid = 1'b0; exp_redirect = 1'b0; exp_cause = 2'd0;
  endtask

  task automatic exp_zero();
    exp_idle();
    exp_ready = 1'b0;
  endtask

  task automatic drive_none();
    bus.execute_memory_valid  = 1'b0;
    bus.execute_memory_load   = 1'b0;
    bus.execute_memory_store  = 1'b0;
    bus.execute_memory_funct3 = 3'd0;
    bus.execute_memory_addr   = '0;
    bus.execute_memory_wdata  = '0;
    bus.execute_memory_result = '0;
    bus.execute_memory_rd     = '0;
    bus.dcache_memory_rdata   = '0;
    bus.dcache_memory_resp    = 1'b0;
  endtask

  // One memory instruction; resp_at = ACCESS cycle carrying resp (0 = never).
  task automatic mem_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int resp_at, input logic [4:0] rd);
    logic [2:0] nf3;
    nf3 = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 3'd2 : f3;
    bus.execute_memory_valid  = 1'b1;
    bus.execute_memory_load   = ld;
    bus.execute_memory_store  = st;
    bus.execute_memory_funct3 = f3;
    bus.execute_memory_addr   = addr;
    bus.execute_memory_wdata  = wd;
    bus.execute_memory_rd     = rd;
    tick();
    drive_none();
    exp_idle();
    if (addr % nbytes(nf3) != 0) begin
      exp_redirect = 1'b1;
      exp_cause    = ld ? 2'd1 : 2'd2;
      $display("txn %s addr=%h misaligned trap", tag, addr);
      return;
    end
    for (int k = 1; k <= TMO; k++) begin
      exp_ready = 1'b0; exp_stall = 1'b1;
      exp_read  = ld;   exp_write = !ld;
      exp_addr  = addr - (addr % 4);
      exp_wdata = model_wdata(wd, addr);
      exp_wmask = model_wmask(addr, nf3);
      bus.dcache_memory_resp  = (k == resp_at);
      bus.dcache_memory_rdata = rdata;
      tick();
      drive_none();
      exp_idle();
      if (k == resp_at) begin
        if (ld) begin
          exp_wb_valid = 1'b1;
          exp_wb_data  = model_load(rdata, addr, nf3);
          exp_wb_rd    = rd;
        end
        $display("txn %s addr=%h resp after %0d cycles model_data=%h", tag, addr, k,
                 ld ? model_load(rdata, addr, nf3) : 32'h0);
        return;
      end
      if (k == TMO) begin
        exp_redirect = 1'b1;
        exp_cause    = 2'd3;
        $display("txn %s addr=%h timeout", tag, addr);
      end
    end
  endtask

  task automatic settle();
    tick();
    exp_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_none();
    exp_zero();
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b0;
    exp_idle();
    $display("txn reset released");

    // Model pinned against hand-computed values.
    chk("model_lb", 64'(model_load(32'h80FF_FF00, 32'h1003, 3'd0)), 64'hFFFF_FF80);
    chk("model_lhu", 64'(model_load(32'hBEEF_1234, 32'h2002, 3'd5)), 64'h0000_BEEF);
    chk("model_lh", 64'(model_load(32'hBEEF_1234, 32'h2002, 3'd1)), 64'hFFFF_BEEF);
    chk("model_sb_wdata", 64'(model_wdata(32'hAB, 32'h3001)), 64'h0000_AB00);
    chk("model_sb_wmask", 64'(model_wmask(32'h3001, 3'd0)), 64'h2);

    // ALU pass-through, three back-to-back.
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        exp_wb_valid = 1'b1;
        exp_wb_data  = 32'(i - 1) * 32'h11;
        exp_wb_rd    = 5'(i - 1);
        $display("txn alu rd=%0d result=%h", i - 1, exp_wb_data);
      end
      bus.execute_memory_valid  = (i <= 3);
      bus.execute_memory_result = 32'(i) * 32'h11;
      bus.execute_memory_rd     = 5'(i);
      if (i <= 3) tick(); else begin drive_none(); settle(); end
      if (i <= 3) exp_idle();
    end
    settle();

    mem_op("lb", 1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_FF00, 2, 5'd5);
    settle();
    chk("lb_literal", 64'(last_wb_data), 64'hFFFF_FF80);
    mem_op("lhu", 1, 0, 3'd5, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 5'd6);
    settle();
    chk("lhu_literal", 64'(last_wb_data), 64'h0000_BEEF);
    mem_op("lh", 1, 0, 3'd1, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 5'd7);
    settle();
    chk("lh_literal", 64'(last_wb_data), 64'hFFFF_BEEF);
    mem_op("sb", 0, 1, 3'd0, 32'h3001, 32'h0000_00AB, 32'h0, 3, 5'd8);
    settle();
    mem_op("sh", 0, 1, 3'd1, 32'h5002, 32'h1234_CDEF, 32'h0, 1, 5'd9);
    settle();
    mem_op("sw_mis", 0, 1, 3'd2, 32'h4002, 32'h1111_2222, 32'h0, 1, 5'd10);
    settle();
    mem_op("lw_mis", 1, 0, 3'd2, 32'h4001, 32'h0, 32'h0, 1, 5'd11);
    settle();
    mem_op("ld_as_lw", 1, 0, 3'd3, 32'h6004, 32'h0, 32'hDEAD_BEEF, 1, 5'd12);
    settle();
    mem_op("ld_and_st", 1, 1, 3'd4, 32'h6006, 32'h55, 32'h7F80_0000, 2, 5'd13);
    settle();
    mem_op("lw_resp_on_last", 1, 0, 3'd2, 32'h6100, 32'h0, 32'h0123_4567, TMO, 5'd14);
    settle();
    mem_op("lw_timeout", 1, 0, 3'd2, 32'h7000, 32'h0, 32'h0, 0, 5'd15);
    settle();

    // Stray response while idle must be ignored.
    bus.dcache_memory_resp = 1'b1;
    bus.dcache_memory_rdata = 32'hFFFF_FFFF;
    tick();
    drive_none();
    $display("txn stray resp in idle");
    settle();

    // Reset in the middle of an access.
    bus.execute_memory_valid = 1'b1;
    bus.execute_memory_load  = 1'b1;
    bus.execute_memory_funct3 = 3'd2;
    bus.execute_memory_addr  = 32'h7100;
    tick();
    drive_none();
    for (int k = 1; k <= 2; k++) begin
      exp_zero(); exp_stall = 1'b1; exp_read = 1'b1; exp_addr = 32'h7100;
      if (k < 2) tick();
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_read_drop", 64'(bus.memory_dcache_read), 64'h0);
    chk("rst_stall_drop", 64'(bus.memory_hazard_stall), 64'h0);
    chk("rst_ready", 64'(bus.memory_execute_ready), 64'h0);
    exp_zero();
    $display("txn reset during access");
    tick();
    rst = 1'b0;
    exp_idle();
    settle();
    settle();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
